// File: rtl/sound_player_pkg.sv
// -----------------------------------------------------------------------------
// sound_player_pkg
// Shared definitions for the sound player and the animation block that drives
// it: the 2-bit sound codes, the player state encoding, and a helper that
// derives a tone's half-period in clock cycles.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package sound_player_pkg;

  typedef enum logic [1:0] {
    CODE_STOP = 2'b00,
    CODE_PONG = 2'b01,
    CODE_PING = 2'b10,
    CODE_GO   = 2'b11
  } sound_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_NOTE1 = 2'b01,
    ST_NOTE2 = 2'b10
  } state_e;

  // Clock cycles per half period of a square wave at tone_hz (floor).
  function automatic int half_period(input int clk_hz, input int tone_hz);
    return clk_hz / (2 * tone_hz);
  endfunction

endpackage

// File: rtl/sound_player_if.sv
// -----------------------------------------------------------------------------
// sound_player_if
// Request/response bundle between the animation logic (master) and the sound
// player (slave).
//   code_sound : sound code, sampled only while sound_req is high
//   sound_req  : one-cycle strobe, play code_sound
//   mute       : level, silences the speaker without affecting timing
//   speaker    : registered square wave to the buzzer pin
//   busy       : high while a tone or sequence is playing
//   playing    : code being played, 00 when idle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface sound_player_if;
  logic [1:0] code_sound;
  logic       sound_req;
  logic       mute;
  logic       speaker;
  logic       busy;
  logic [1:0] playing;

  modport master (
    output code_sound, sound_req, mute,
    input  speaker, busy, playing
  );

  modport slave (
    input  code_sound, sound_req, mute,
    output speaker, busy, playing
  );
endinterface

// File: rtl/sound_tone_gen.sv
// -----------------------------------------------------------------------------
// sound_tone_gen
// Loadable half-period divider producing a 50% square-wave phase.
//   clk     : system clock
//   clr     : asynchronous active-low reset
//   load_i  : restart the count and force the phase high
//   half_i  : half period in clocks (>= 2), held stable between loads
//   phase_o : phase for the coming cycle (combinational); the caller registers
//             it so the speaker edge lines up with the load edge
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sound_tone_gen (
  input  logic        clk,
  input  logic        clr,
  input  logic        load_i,
  input  logic [15:0] half_i,
  output logic        phase_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic        wrap;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    wrap    = (cnt_q == half_i - 16'd1);
    cnt_d   = cnt_q + 16'd1;
    phase_d = phase_q;
    if (load_i) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (wrap) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  assign phase_o = phase_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/sound_player.sv
// -----------------------------------------------------------------------------
// sound_player
// Plays a timed square-wave tone for each request from the animation logic;
// "go" plays two rising notes back to back. A new request preempts whatever is
// playing; code 00 stops immediately.
//   clk : system clock, rising edge
//   clr : asynchronous active-low reset
//   snd : sound_player_if.slave (code_sound, sound_req, mute in;
//         speaker, busy, playing out)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sound_player
  import sound_player_pkg::*;
#(
  parameter int CLK_HZ  = 12_000_000,
  parameter int PING_HZ = 880,
  parameter int PONG_HZ = 440,
  parameter int GO1_HZ  = 523,
  parameter int GO2_HZ  = 784,
  parameter int TONE_MS = 80
) (
  input  logic           clk,
  input  logic           clr,
  sound_player_if.slave  snd
);

  localparam int TICK      = CLK_HZ / 1000;
  localparam int HALF_PING = half_period(CLK_HZ, PING_HZ);
  localparam int HALF_PONG = half_period(CLK_HZ, PONG_HZ);
  localparam int HALF_GO1  = half_period(CLK_HZ, GO1_HZ);
  localparam int HALF_GO2  = half_period(CLK_HZ, GO2_HZ);
  localparam int MS_W      = $clog2(TICK);
  localparam int NOTE_W    = (TONE_MS > 1) ? $clog2(TONE_MS) : 1;

  if (TICK < 2 || HALF_PING < 2 || HALF_PONG < 2 || HALF_GO1 < 2 || HALF_GO2 < 2 ||
      HALF_PING > 65535 || HALF_PONG > 65535 || HALF_GO1 > 65535 || HALF_GO2 > 65535 ||
      TONE_MS < 1 || TONE_MS > 1023) begin : g_bad_params
    $fatal(1, "sound_player: derived half-periods/ms tick must be 2..65535, TONE_MS 1..1023");
  end

  state_e              state_q, state_d;
  sound_code_e         playing_q, playing_d;
  sound_code_e         code;
  logic [MS_W-1:0]     ms_cnt_q;
  logic [NOTE_W-1:0]   note_cnt_q;
  logic [15:0]         half_q, half_d;
  logic                busy_q, speaker_q;
  logic                note_end, load, phase_next;

  always_comb begin
    code      = sound_code_e'(snd.code_sound);
    note_end  = (ms_cnt_q == MS_W'(TICK - 1)) && (note_cnt_q == NOTE_W'(TONE_MS - 1));
    state_d   = state_q;
    playing_d = playing_q;
    load      = 1'b0;
    // A request always beats a note ending on the same edge.
    if (snd.sound_req) begin
      if (code == CODE_STOP) begin
        state_d   = ST_IDLE;
        playing_d = CODE_STOP;
      end else begin
        state_d   = ST_NOTE1;
        playing_d = code;
        load      = 1'b1;
      end
    end else if (state_q != ST_IDLE && note_end) begin
      if (state_q == ST_NOTE1 && playing_q == CODE_GO) begin
        state_d = ST_NOTE2;
        load    = 1'b1;
      end else begin
        state_d   = ST_IDLE;
        playing_d = CODE_STOP;
      end
    end

    // Half period only changes on a load, so the divider never sees it shrink
    // under a running count.
    half_d = half_q;
    if (load) begin
      unique case (playing_d)
        CODE_PONG: half_d = 16'(HALF_PONG);
        CODE_PING: half_d = 16'(HALF_PING);
        CODE_GO:   half_d = (state_d == ST_NOTE2) ? 16'(HALF_GO2) : 16'(HALF_GO1);
        default:   half_d = half_q;
      endcase
    end
  end

  sound_tone_gen u_tone (
    .clk     (clk),
    .clr     (clr),
    .load_i  (load),
    .half_i  (half_d),
    .phase_o (phase_next)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      playing_q  <= CODE_STOP;
      busy_q     <= 1'b0;
      speaker_q  <= 1'b0;
      ms_cnt_q   <= '0;
      note_cnt_q <= '0;
      half_q     <= 16'(HALF_PING);
    end else begin
      state_q   <= state_d;
      playing_q <= playing_d;
      busy_q    <= (state_d != ST_IDLE);
      speaker_q <= (state_d != ST_IDLE) && phase_next && !snd.mute;
      half_q    <= half_d;
      // Counters restart on every note entry and rest at zero while idle, so a
      // note lasts exactly TONE_MS*TICK clocks from its entry edge.
      if (load || state_d == ST_IDLE) begin
        ms_cnt_q   <= '0;
        note_cnt_q <= '0;
      end else if (ms_cnt_q == MS_W'(TICK - 1)) begin
        ms_cnt_q   <= '0;
        note_cnt_q <= note_cnt_q + NOTE_W'(1);
      end else begin
        ms_cnt_q <= ms_cnt_q + MS_W'(1);
      end
    end
  end

  assign snd.speaker = speaker_q;
  assign snd.busy    = busy_q;
  assign snd.playing = playing_q;

endmodule

// File: tb/tb_sound_player.sv
// -----------------------------------------------------------------------------
// tb_sound_player
// Directed bench for sound_player with a 20 kHz clock: 20-clock ms tick,
// 60-clock notes, half-periods ping 10, pong 20, go 10 then 5.
// Inputs change on the falling edge; outputs are sampled there too, so each
// sample shows the state after the preceding rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sound_player;
  import sound_player_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sound_player_if snd ();

  sound_player #(
    .CLK_HZ  (20_000),
    .PING_HZ (1000),
    .PONG_HZ (500),
    .GO1_HZ  (1000),
    .GO2_HZ  (2000),
    .TONE_MS (3)
  ) dut (
    .clk (clk),
    .clr (clr),
    .snd (snd)
  );

  // Pulse sound_req for one rising edge; returns at the falling edge of the
  // first cycle after acceptance (cycle 0 of the new note).
  task automatic req(input logic [1:0] c);
    snd.code_sound = c;
    snd.sound_req  = 1'b1;
    @(negedge clk);
    snd.sound_req  = 1'b0;
  endtask

  // Record n cycles of outputs, one sample per falling edge.
  task automatic capture(input int n, output logic [127:0] spk,
                         output logic [127:0] bsy, output logic [255:0] pl);
    spk = '0; bsy = '0; pl = '0;
    for (int i = 0; i < n; i++) begin
      spk[i]         = snd.speaker;
      bsy[i]         = snd.busy;
      pl[2*i +: 2]   = snd.playing;
      @(negedge clk);
    end
  endtask

  function automatic logic [127:0] ones(input int n);
    logic [127:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [255:0] rep(input int n, input logic [1:0] v);
    logic [255:0] r = '0;
    for (int i = 0; i < n; i++) r[2*i +: 2] = v;
    return r;
  endfunction

  // Square wave starting high, 'half' clocks per level.
  function automatic logic [127:0] square(input int n, input int half);
    logic [127:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = ((i / half) % 2) == 0;
    return r;
  endfunction

  task automatic test_reset();
    logic [3:0] obs;
    #12;
    obs = {snd.speaker, snd.busy, snd.playing};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", obs);
    end
    @(negedge clk);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    obs = {snd.speaker, snd.busy, snd.playing};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 0000", obs);
    end
  endtask

  task automatic test_ping();
    logic [127:0] spk, bsy, exp_spk;
    logic [255:0] pl;
    logic [3:0]   obs;
    req(CODE_PING);
    snd.code_sound = CODE_PONG;  // no strobe: must be ignored
    capture(60, spk, bsy, pl);
    exp_spk = square(60, 10);
    checks++;
    if (spk !== exp_spk) begin
      errors++; $display("FAIL ping_wave: got %h expected %h", spk, exp_spk);
    end
    checks++;
    if (bsy !== ones(60)) begin
      errors++; $display("FAIL ping_busy: got %h expected %h", bsy, ones(60));
    end
    checks++;
    if (pl !== rep(60, CODE_PING)) begin
      errors++; $display("FAIL ping_playing: got %h expected %h", pl, rep(60, CODE_PING));
    end
    obs = {snd.speaker, snd.busy, snd.playing};
    checks++;
    if (obs !== 4'b0000) begin
      errors++; $display("FAIL ping_end_idle: got %b expected 0000", obs);
    end
  endtask

  task automatic test_go();
    logic [127:0] spk, bsy, exp_spk;
    logic [255:0] pl;
    logic [3:0]   obs;
    req(CODE_GO);
    capture(120, spk, bsy, pl);
    exp_spk = '0;
    for (int i = 0; i < 120; i++)
      exp_spk[i] = (i < 60) ? (((i / 10) % 2) == 0) : ((((i - 60) / 5) % 2) == 0);
    checks++;
    if (spk !== exp_spk) begin
      errors++; $display("FAIL go_wave: got %h expected %h", spk, exp_spk);
    end
    checks++;
    if (bsy !== ones(120)) begin
      errors++; $display("FAIL go_busy: got %h expected %h", bsy, ones(120));
    end
    checks++;
    if (pl !== rep(120, CODE_GO)) begin
      errors++; $display("FAIL go_playing: got %h expected %h", pl, rep(120, CODE_GO));
    end
    obs = {snd.speaker, snd.busy, snd.playing};
    checks++;
    if (obs !== 4'b0000) begin
      errors++; $display("FAIL go_end_idle: got %b expected 0000", obs);
    end
  endtask

  task automatic test_preempt();
    logic [127:0] spk, bsy, exp_spk;
    logic [255:0] pl;
    logic [3:0]   obs;
    req(CODE_PONG);
    capture(25, spk, bsy, pl);
    exp_spk = square(25, 20);
    checks++;
    if (spk !== exp_spk) begin
      errors++; $display("FAIL pong_wave: got %h expected %h", spk, exp_spk);
    end
    checks++;
    if (pl !== rep(25, CODE_PONG)) begin
      errors++; $display("FAIL pong_playing: got %h expected %h", pl, rep(25, CODE_PONG));
    end
    req(CODE_PING);
    capture(60, spk, bsy, pl);
    exp_spk = square(60, 10);
    checks++;
    if (spk !== exp_spk) begin
      errors++; $display("FAIL preempt_wave: got %h expected %h", spk, exp_spk);
    end
    checks++;
    if (bsy !== ones(60)) begin
      errors++; $display("FAIL preempt_busy: got %h expected %h", bsy, ones(60));
    end
    checks++;
    if (pl !== rep(60, CODE_PING)) begin
      errors++; $display("FAIL preempt_playing: got %h expected %h", pl, rep(60, CODE_PING));
    end
    obs = {snd.speaker, snd.busy, snd.playing};
    checks++;
    if (obs !== 4'b0000) begin
      errors++; $display("FAIL preempt_end_idle: got %b expected 0000", obs);
    end
  endtask

  task automatic test_mute();
    logic [127:0] spk, bsy, exp_spk;
    logic [3:0]   obs;
    spk = '0; bsy = '0; exp_spk = '0;
    req(CODE_PING);
    for (int k = 0; k < 60; k++) begin
      spk[k] = snd.speaker;
      bsy[k] = snd.busy;
      exp_spk[k] = (((k / 10) % 2) == 0) && !(k >= 6 && k <= 31);
      snd.mute = (k >= 5 && k <= 30);
      @(negedge clk);
    end
    snd.mute = 1'b0;
    checks++;
    if (spk !== exp_spk) begin
      errors++; $display("FAIL mute_wave: got %h expected %h", spk, exp_spk);
    end
    checks++;
    if (bsy !== ones(60)) begin
      errors++; $display("FAIL mute_busy: got %h expected %h", bsy, ones(60));
    end
    obs = {snd.speaker, snd.busy, snd.playing};
    checks++;
    if (obs !== 4'b0000) begin
      errors++; $display("FAIL mute_end_idle: got %b expected 0000", obs);
    end
    // Request while muted: silent, but busy/playing as normal.
    snd.mute = 1'b1;
    req(CODE_PING);
    obs = {snd.speaker, snd.busy, snd.playing};
    checks++;
    if (obs !== 4'b0110) begin
      errors++; $display("FAIL muted_request: got %b expected 0110", obs);
    end
    snd.mute = 1'b0;
    @(negedge clk);
    checks++;
    if (snd.speaker !== 1'b1) begin
      errors++; $display("FAIL unmute_speaker: got %b expected 1", snd.speaker);
    end
    req(CODE_STOP);
    obs = {snd.speaker, snd.busy, snd.playing};
    checks++;
    if (obs !== 4'b0000) begin
      errors++; $display("FAIL muted_stop: got %b expected 0000", obs);
    end
  endtask

  task automatic test_stop_clr();
    logic [127:0] spk, bsy;
    logic [255:0] pl;
    logic [3:0]   obs;
    req(CODE_GO);
    capture(40, spk, bsy, pl);
    obs = {snd.speaker, snd.busy, snd.playing};
    checks++;
    if (obs !== 4'b1111) begin
      errors++; $display("FAIL go_mid_note1: got %b expected 1111", obs);
    end
    req(CODE_STOP);
    obs = {snd.speaker, snd.busy, snd.playing};
    checks++;
    if (obs !== 4'b0000) begin
      errors++; $display("FAIL stop_request: got %b expected 0000", obs);
    end
    req(CODE_GO);
    capture(80, spk, bsy, pl);
    obs = {snd.speaker, snd.busy, snd.playing};
    checks++;
    if (obs !== 4'b1111) begin
      errors++; $display("FAIL go_mid_note2: got %b expected 1111", obs);
    end
    #2 clr = 1'b0;
    #1;
    obs = {snd.speaker, snd.busy, snd.playing};
    checks++;
    if (obs !== 4'b0000) begin
      errors++; $display("FAIL async_clr: got %b expected 0000", obs);
    end
    @(negedge clk);
    clr = 1'b1;
    capture(10, spk, bsy, pl);
    checks++;
    if ({spk, bsy} !== '0 || pl !== '0) begin
      errors++; $display("FAIL no_resume: got spk %h busy %h playing %h expected all 0", spk, bsy, pl);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] spk, bsy, exp_spk;
    logic [255:0] pl;
    logic [3:0]   obs;
    req(CODE_PING);
    capture(59, spk, bsy, pl);
    checks++;
    if (snd.busy !== 1'b1) begin
      errors++; $display("FAIL ping_last_cycle_busy: got %b expected 1", snd.busy);
    end
    // Strobe lands on the edge where the ping note ends.
    req(CODE_PONG);
    capture(60, spk, bsy, pl);
    exp_spk = square(60, 20);
    checks++;
    if (spk !== exp_spk) begin
      errors++; $display("FAIL b2b_wave: got %h expected %h", spk, exp_spk);
    end
    checks++;
    if (bsy !== ones(60)) begin
      errors++; $display("FAIL b2b_busy: got %h expected %h", bsy, ones(60));
    end
    checks++;
    if (pl !== rep(60, CODE_PONG)) begin
      errors++; $display("FAIL b2b_playing: got %h expected %h", pl, rep(60, CODE_PONG));
    end
    obs = {snd.speaker, snd.busy, snd.playing};
    checks++;
    if (obs !== 4'b0000) begin
      errors++; $display("FAIL b2b_end_idle: got %b expected 0000", obs);
    end
  endtask

  initial begin
    snd.code_sound = CODE_STOP;
    snd.sound_req  = 1'b0;
    snd.mute       = 1'b0;
    test_reset();
    test_ping();
    test_go();
    test_preempt();
    test_mute();
    test_stop_clr();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
